operand_select_fifo: RTL
========================

// Module: operand_select_fifo
// PURPOSE
//  Parametrised N-way ALU operand selector with a small buffered output stage.
//  Each accepted transaction uses sel_in to pick one of NUM_IN source words
//  (PC, reg A, ALUOut, MDR, ...) and queues it with a valid/ready handshake.
//  The ALU side pops queued operands, which decouples the control FSM from the ALU.
// PARAMETERS
//  DATA_W  32  width of each source word and of out_data
//  NUM_IN  4   number of selectable sources (2..16)
//  SEL_W   2   width of sel_in; must satisfy 2**SEL_W >= NUM_IN
//  DEPTH   2   FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               asynchronous, active-high reset
//  flush      in   1               synchronous queue clear
//  sel_in     in   SEL_W           source index for this transaction
//  data_in    in   NUM_IN*DATA_W   flattened sources; source k = data_in[k*DATA_W +: DATA_W]
//  in_valid   in   1               producer presents sel_in/data_in
//  in_ready   out  1               block can accept an entry this cycle
//  out_data   out  DATA_W          head-of-queue operand
//  out_sel    out  SEL_W           sel_in value captured with the head entry
//  out_valid  out  1               head entry is valid
//  out_ready  in   1               consumer takes the head entry this cycle
//  count      out  clog2(DEPTH)+1  number of occupied entries
//  sel_err    out  1               one-cycle pulse: out-of-range sel_in was accepted
// BEHAVIOUR
//  - Reset (async): count=0, read/write pointers=0, out_valid=0, out_data=0,
//    out_sel=0, sel_err=0. This also applies when reset is asserted mid-transfer.
//    All queued entries are discarded.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count < DEPTH), decoded from registers only; it has no
//    combinational path from in_valid or out_ready.
//  - out_valid = (count != 0). out_data and out_sel show the head entry and are
//    forced to 0 when the queue is empty.
//  - Push: store {sel_in, data_in[sel_in]} at wptr; wptr = wptr+1 mod DEPTH.
//  - Pop: rptr = rptr+1 mod DEPTH. Pointers wrap silently.
//  - Latency: an entry pushed in cycle t is visible on out_* in cycle t+1.
//    There is no same-cycle pass-through, including when the queue is empty.
//  - Push and pop in the same cycle: count is unchanged and both pointers advance.
//  - When full, in_ready=0, so a pop in that cycle does not admit a push. in_ready
//    rises in the following cycle.
//  - Pop while empty is ignored (out_valid=0). Push while full cannot occur.
//  - sel_in >= NUM_IN on a push: the stored data is 0 and the stored out_sel is
//    the raw sel_in. sel_err=1 in the next cycle, for exactly one cycle.
//  - flush=1: count=0 and pointers=0 on the next edge. flush overrides any push or
//    pop in the same cycle, and no sel_err is raised for an entry dropped by it.
//  - count arithmetic is done at clog2(DEPTH)+1 bits and never over- or underflows.
// TESTING
//  1 Reset then idle: out_valid=0, in_ready=1, count=0, out_data=0 for 10 cycles.
//  2 NUM_IN=4, data_in={D3..D0}=32'h33,22,11,00. Push sel=2 with out_ready=0:
//    next cycle out_data=32'h22, out_sel=2, count=1.
//  3 Fill to DEPTH=2 with out_ready=0: in_ready=0. Then push+pop in the same cycle:
//    only the pop takes effect, count=1, and in_ready=1 in the next cycle.
//  4 Steady stream, in_valid=out_ready=1, sel cycling 0,1,2,3 over 8 pushes:
//    outputs arrive in order at one per cycle and both pointers wrap correctly.
//  5 NUM_IN=3, push sel=3: stored out_data=0, out_sel=3, one-cycle sel_err pulse.
//  6 Two entries queued, assert reset mid-cycle (asynchronously): out_valid=0 and
//    count=0 immediately. Repeat with flush: both cleared on the next edge.

Source files
------------

// File: rtl/operand_select_fifo.sv
// N-way ALU operand selector feeding a small FIFO; each push captures the chosen
// source word plus the raw select, and the ALU side pops operands one per cycle.
module operand_select_fifo #(
   parameter int DATA_W = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2,
   parameter int DEPTH  = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   input  logic [SEL_W-1:0]            sel_in,
   input  logic [NUM_IN*DATA_W-1:0]    data_in,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [SEL_W-1:0]            out_sel,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        sel_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] r_dataMem [DEPTH];
   logic [SEL_W-1:0]  r_selMem  [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_selErr;

   logic              w_push;
   logic              w_pop;
   logic              w_selBad;
   logic [DATA_W-1:0] w_selData;

   // Out-of-range selects fall through the mux with the zero default.
   always_comb begin
      w_selData = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel_in == SEL_W'(k)) begin
            w_selData = data_in[k*DATA_W +: DATA_W];
         end
      end
   end

   assign w_selBad  = ({1'b0, sel_in} >= (SEL_W+1)'(NUM_IN));
   assign in_ready  = (r_count < CNT_W'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign out_data  = out_valid ? r_dataMem[r_rptr] : '0;
   assign out_sel   = out_valid ? r_selMem[r_rptr]  : '0;
   assign count     = r_count;
   assign sel_err   = r_selErr;

   // Payload storage needs no reset: empty slots are never visible on the outputs.
   always_ff @(posedge clk) begin
      if (w_push && !flush) begin
         r_dataMem[r_wptr] <= w_selData;
         r_selMem[r_wptr]  <= sel_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_selErr <= 1'b0;
      end else if (flush) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_selErr <= 1'b0;
      end else begin
         r_selErr <= w_push & w_selBad;
         if (w_push) begin
            r_wptr <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
